hasti_wb_bridge: RTL and testbench

Single-master AHB-Lite (HASTI) slave to Wishbone classic master bridge. It sits directly downstream of one vscale_core memory port (imem_* or dmem_*). It converts each HASTI NONSEQ/SEQ transfer into exactly one Wishbone single read or write cycle and stalls the core with hready until the cycle completes. One transfer is outstanding at a time; address and data phases are pipelined per HASTI.

---
 rtl/hasti_wb_bridge.sv | 155 +++++++++++++++
 tb/tb_hasti_wb_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hasti_wb_bridge.sv
// HASTI (AHB-Lite) slave to Wishbone classic master bridge.
// Each accepted NONSEQ/SEQ transfer becomes one Wishbone single cycle; hready stalls the core.
module hasti_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e      state_q;
    logic [15:0] tmo_q;
    logic [31:0] adr_q;
    logic [31:0] rdata_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic        cyc_q;
    logic        hready_q;
    logic        hresp_q;

    logic [3:0]  sel_d;
    logic        legal_d;
    logic        tmo_hit;

    // Lane enables and natural-alignment check for the address-phase transfer.
    always_comb begin
        sel_d   = '0;
        legal_d = 1'b0;
        case (hsize)
            3'd0: begin
                sel_d   = 4'b0001 << haddr[1:0];
                legal_d = 1'b1;
            end
            3'd1: begin
                sel_d   = haddr[1] ? 4'b1100 : 4'b0011;
                legal_d = ~haddr[0];
            end
            3'd2: begin
                sel_d   = '1;
                legal_d = (haddr[1:0] == 2'b00);
            end
            default: begin
                sel_d   = '0;
                legal_d = 1'b0;
            end
        endcase
    end

    // tmo_q counts ACCESS cycles including the current one, so a limit of N allows N cycles.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            tmo_q    <= '0;
            adr_q    <= '0;
            rdata_q  <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            case (state_q)
                S_ACCESS: begin
                    if (wb_err_i) begin
                        state_q  <= S_ERR1;
                        cyc_q    <= 1'b0;
                        hready_q <= 1'b0;
                        hresp_q  <= 1'b1;
                    end else if (wb_ack_i) begin
                        state_q  <= S_DONE;
                        cyc_q    <= 1'b0;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= wb_dat_i;
                        end
                    end else if (tmo_hit) begin
                        state_q  <= S_ERR1;
                        cyc_q    <= 1'b0;
                        hready_q <= 1'b0;
                        hresp_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_ERR1: begin
                    state_q  <= S_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b1;
                end
                default: begin
                    // IDLE, DONE and ERR2 all present hready=1 and accept the next transfer.
                    if (htrans[1]) begin
                        adr_q <= {haddr[31:2], 2'b00};
                        we_q  <= hwrite;
                        sel_q <= sel_d;
                        if (legal_d) begin
                            state_q  <= S_ACCESS;
                            cyc_q    <= 1'b1;
                            tmo_q    <= 16'd1;
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b0;
                        end else begin
                            state_q  <= S_ERR1;
                            cyc_q    <= 1'b0;
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b1;
                        end
                    end else begin
                        state_q  <= S_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign hrdata   = rdata_q;
    assign hready   = hready_q;
    assign hresp    = hresp_q;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_dat_o = hwdata;

endmodule

// File: tb/tb_hasti_wb_bridge.sv
// Directed self-checking bench for hasti_wb_bridge (timeout limit set to 4 cycles).
module tb_hasti_wb_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int checks   = 0;
    int failures = 0;
    int cyc_pulses = 0;
    int pulses_start;
    logic cyc_prev = 1'b0;

    hasti_wb_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .haddr    (haddr),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .htrans   (htrans),
        .hwdata   (hwdata),
        .hrdata   (hrdata),
        .hready   (hready),
        .hresp    (hresp),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wb_cyc_o && !cyc_prev) cyc_pulses++;
        cyc_prev <= wb_cyc_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
        htrans = 2'd2;
        haddr  = a;
        hwrite = w;
        hsize  = s;
    endtask

    initial begin
        reset_n = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd2; htrans = 2'd0;
        hwdata = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        tick();
        tick();
        check("rst_hready", {31'd0, hready}, 32'd1);
        check("rst_hresp", {31'd0, hresp}, 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("rst_we", {31'd0, wb_we_o}, 32'd0);
        check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        reset_n = 1'b1;

        // BUSY with hready=1: zero-wait OKAY, no cycle
        htrans = 2'd1;
        tick();
        check("busy_hready", {31'd0, hready}, 32'd1);
        check("busy_cyc", {31'd0, wb_cyc_o}, 32'd0);

        // word read, ack in first ACCESS cycle
        addr_phase(32'h0000_1004, 1'b0, 3'd2);
        tick();
        htrans = 2'd0;
        check("rd_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
        check("rd_adr", wb_adr_o, 32'h0000_1004);
        check("rd_sel", {28'd0, wb_sel_o}, 32'hF);
        check("rd_we", {31'd0, wb_we_o}, 32'd0);
        check("rd_hready0", {31'd0, hready}, 32'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEADBEEF;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = 32'h1234_5678;
        check("rd_hready1", {31'd0, hready}, 32'd1);
        check("rd_hresp", {31'd0, hresp}, 32'd0);
        check("rd_hrdata", hrdata, 32'hDEADBEEF);
        check("rd_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
        tick();

        // byte write at 0x2003, then back-to-back half write at 0x2002 from DONE
        addr_phase(32'h0000_2003, 1'b1, 3'd0);
        tick();
        htrans = 2'd0; hwdata = 32'hAABBCCDD;
        check("bw_sel", {28'd0, wb_sel_o}, 32'h8);
        check("bw_we", {31'd0, wb_we_o}, 32'd1);
        check("bw_dat", wb_dat_o, 32'hAABBCCDD);
        check("bw_adr", wb_adr_o, 32'h0000_2000);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("bw_done", {31'd0, hready}, 32'd1);
        check("bw_hrdata_hold", hrdata, 32'hDEADBEEF);
        addr_phase(32'h0000_2002, 1'b1, 3'd1);
        tick();
        htrans = 2'd0;
        check("hw_sel", {28'd0, wb_sel_o}, 32'hC);
        check("hw_cyc", {31'd0, wb_cyc_o}, 32'd1);
        check("hw_hready0", {31'd0, hready}, 32'd0);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("hw_done", {31'd0, hready}, 32'd1);
        tick();

        // three back-to-back reads, ack latency 2
        pulses_start = cyc_pulses;
        addr_phase(32'h0000_0100, 1'b0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_cyc", {31'd0, wb_cyc_o}, 32'd1);
            check("b2b_adr", wb_adr_o, 32'h0000_0100 + 32'(4 * i));
            check("b2b_dp1", {31'd0, hready}, 32'd0);
            if (i < 2) haddr = 32'h0000_0100 + 32'(4 * (i + 1));
            else htrans = 2'd0;
            tick();
            check("b2b_dp2", {31'd0, hready}, 32'd0);
            wb_ack_i = 1'b1; wb_dat_i = 32'hC0DE_0000 + 32'(i);
            tick();
            wb_ack_i = 1'b0;
            check("b2b_dp3", {31'd0, hready}, 32'd1);
            check("b2b_hrdata", hrdata, 32'hC0DE_0000 + 32'(i));
        end
        tick();
        check("b2b_idle_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("b2b_pulses", 32'(cyc_pulses - pulses_start), 32'd3);

        // Wishbone error on a write, ack asserted together (err wins)
        addr_phase(32'h0000_0400, 1'b1, 3'd2);
        tick();
        htrans = 2'd0; hwdata = 32'h0BAD_F00D;
        wb_err_i = 1'b1; wb_ack_i = 1'b1;
        tick();
        wb_err_i = 1'b0; wb_ack_i = 1'b0;
        check("err1_rdy_resp", {30'd0, hready, hresp}, 32'b01);
        check("err1_cyc", {31'd0, wb_cyc_o}, 32'd0);
        tick();
        check("err2_rdy_resp", {30'd0, hready, hresp}, 32'b11);
        tick();
        check("err_after", {30'd0, hready, hresp}, 32'b10);

        // misaligned word at 0x3002: error without any cycle
        pulses_start = cyc_pulses;
        addr_phase(32'h0000_3002, 1'b0, 3'd2);
        tick();
        htrans = 2'd0;
        check("mis_err1", {30'd0, hready, hresp}, 32'b01);
        check("mis_cyc1", {31'd0, wb_cyc_o}, 32'd0);
        tick();
        check("mis_err2", {30'd0, hready, hresp}, 32'b11);
        check("mis_cyc2", {31'd0, wb_cyc_o}, 32'd0);
        tick();
        check("mis_pulses", 32'(cyc_pulses - pulses_start), 32'd0);

        // timeout: 4 ACCESS cycles without ack, then ERR1/ERR2
        addr_phase(32'h0000_0500, 1'b0, 3'd2);
        tick();
        htrans = 2'd0;
        check("tmo_c1", {30'd0, wb_cyc_o, hready}, 32'b10);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check("tmo_cn", {30'd0, wb_cyc_o, hready}, 32'b10);
        end
        tick();
        check("tmo_err1", {30'd0, hready, hresp}, 32'b01);
        check("tmo_cyc", {31'd0, wb_cyc_o}, 32'd0);
        tick();
        check("tmo_err2", {30'd0, hready, hresp}, 32'b11);
        tick();

        // reset during ACCESS with a late ack
        addr_phase(32'h0000_0600, 1'b1, 3'd2);
        tick();
        htrans = 2'd0;
        check("mrst_cyc", {31'd0, wb_cyc_o}, 32'd1);
        reset_n = 1'b0;
        wb_ack_i = 1'b1;
        tick();
        check("mrst_cyc0", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("mrst_rdy_resp", {30'd0, hready, hresp}, 32'b10);
        check("mrst_hrdata", hrdata, 32'd0);
        check("mrst_adr", wb_adr_o, 32'd0);
        check("mrst_sel_we", {27'd0, wb_sel_o, wb_we_o}, 32'd0);
        reset_n = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("mrst_after", {30'd0, wb_cyc_o, hready}, 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
